// File: rtl/filter_buffer.sv
// Banked filter store: a beat stream fills NB_FILTER banks round-robin; all banks are read in parallel.
// Reads take 1 cycle and never stall. o_wr_rdy is high only while a load is in progress.

`ifndef FILTER_DW
`define FILTER_DW 8
`endif
`ifndef BUFFER_ADDRESS_BW
`define BUFFER_ADDRESS_BW 4
`endif
`ifndef FILTER_BUFFER_CNT
`define FILTER_BUFFER_CNT 4
`endif

module filter_buffer #(
  parameter int FILTER_DW = `FILTER_DW,
  parameter int BUF_AW    = `BUFFER_ADDRESS_BW,
  parameter int NB_FILTER = `FILTER_BUFFER_CNT
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 i_load_start,
  input  logic [BUF_AW:0]      i_load_words,
  input  logic                 i_wr_vld,
  input  logic [FILTER_DW-1:0] i_wr_data,
  output logic                 o_wr_rdy,
  output logic                 o_loaded,
  output logic                 o_load_done,
  input  logic                 i_fb_req,
  input  logic [BUF_AW-1:0]    i_fb_addr,
  output logic [FILTER_DW-1:0] fb_data0_out,
  output logic [FILTER_DW-1:0] fb_data1_out,
  output logic [FILTER_DW-1:0] fb_data2_out,
  output logic [FILTER_DW-1:0] fb_data3_out,
  output logic                 o_rd_err
);

  localparam int DEPTH = 1 << BUF_AW;
  localparam int SEL_W = $clog2(NB_FILTER);
  localparam int CNT_W = BUF_AW + SEL_W + 1;
  localparam logic [BUF_AW:0] W_MAX = (BUF_AW+1)'(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_READY} state_t;

  state_t               state_q, state_d;
  logic [BUF_AW:0]      w_q;
  logic [BUF_AW:0]      w_sat;
  logic [CNT_W-1:0]     cnt_q;
  logic [CNT_W-1:0]     total_beats;
  logic                 start_ok;
  logic                 wr_fire;
  logic                 last_beat;
  logic [SEL_W-1:0]     wr_bank;
  logic [BUF_AW-1:0]    wr_addr;

  logic [FILTER_DW-1:0] mem [NB_FILTER][DEPTH];
  logic [FILTER_DW-1:0] rd_q [NB_FILTER];

  assign w_sat       = (i_load_words > W_MAX) ? W_MAX : i_load_words;
  assign start_ok    = i_load_start && (state_q != S_LOAD);
  assign wr_fire     = i_wr_vld && o_wr_rdy;
  assign total_beats = CNT_W'(w_q) * CNT_W'(NB_FILTER);
  assign last_beat   = wr_fire && (cnt_q == total_beats - CNT_W'(1));
  // Beat k lands in bank k mod NB_FILTER at row k / NB_FILTER.
  assign wr_bank     = cnt_q[SEL_W-1:0];
  assign wr_addr     = cnt_q[SEL_W +: BUF_AW];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_READY: begin
        if (i_load_start) state_d = (w_sat == '0) ? S_READY : S_LOAD;
      end
      S_LOAD: begin
        if (last_beat) state_d = S_READY;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    o_wr_rdy = (state_q == S_LOAD);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      w_q         <= '0;
      cnt_q       <= '0;
      o_loaded    <= 1'b0;
      o_load_done <= 1'b0;
    end else begin
      o_load_done <= 1'b0;
      if (start_ok) begin
        w_q   <= w_sat;
        cnt_q <= '0;
        if (w_sat == '0) begin
          o_load_done <= 1'b1;
          o_loaded    <= 1'b1;
        end else begin
          o_loaded <= 1'b0;
        end
      end else if (wr_fire) begin
        cnt_q <= cnt_q + CNT_W'(1);
        if (last_beat) begin
          o_load_done <= 1'b1;
          o_loaded    <= 1'b1;
        end
      end
    end
  end

  // Storage is deliberately not reset; a same-cycle read sees the pre-write word.
  always_ff @(posedge clk) begin
    if (wr_fire) mem[wr_bank][wr_addr] <= i_wr_data;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int b = 0; b < NB_FILTER; b++) rd_q[b] <= '0;
      o_rd_err <= 1'b0;
    end else begin
      if (i_fb_req) begin
        for (int b = 0; b < NB_FILTER; b++) rd_q[b] <= mem[b][i_fb_addr];
      end
      o_rd_err <= i_fb_req && ((state_q != S_READY) || ({1'b0, i_fb_addr} >= w_q));
    end
  end

  assign fb_data0_out = rd_q[0];
  assign fb_data1_out = rd_q[1];
  assign fb_data2_out = rd_q[2];
  assign fb_data3_out = rd_q[3];

endmodule

// File: tb/tb_filter_buffer.sv
// Directed bench for filter_buffer: load sequencing, banked placement, read timing/errors, reset.
module tb_filter_buffer;

  localparam int DW = 8;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          rstn;
  logic          i_load_start;
  logic [AW:0]   i_load_words;
  logic          i_wr_vld;
  logic [DW-1:0] i_wr_data;
  logic          o_wr_rdy;
  logic          o_loaded;
  logic          o_load_done;
  logic          i_fb_req;
  logic [AW-1:0] i_fb_addr;
  logic [DW-1:0] fb_data0_out, fb_data1_out, fb_data2_out, fb_data3_out;
  logic          o_rd_err;
  logic [DW-1:0] fbd [4];

  int total  = 0;
  int passed = 0;

  filter_buffer dut (
    .clk          (clk),
    .rstn         (rstn),
    .i_load_start (i_load_start),
    .i_load_words (i_load_words),
    .i_wr_vld     (i_wr_vld),
    .i_wr_data    (i_wr_data),
    .o_wr_rdy     (o_wr_rdy),
    .o_loaded     (o_loaded),
    .o_load_done  (o_load_done),
    .i_fb_req     (i_fb_req),
    .i_fb_addr    (i_fb_addr),
    .fb_data0_out (fb_data0_out),
    .fb_data1_out (fb_data1_out),
    .fb_data2_out (fb_data2_out),
    .fb_data3_out (fb_data3_out),
    .o_rd_err     (o_rd_err)
  );

  assign fbd[0] = fb_data0_out;
  assign fbd[1] = fb_data1_out;
  assign fbd[2] = fb_data2_out;
  assign fbd[3] = fb_data3_out;

  always #5 clk = ~clk;

  // Advance one cycle; outputs are then sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_start(input int words);
    i_load_start = 1'b1;
    i_load_words = (AW+1)'(words);
    step();
    i_load_start = 1'b0;
  endtask

  task automatic read_req(input int addr);
    i_fb_req  = 1'b1;
    i_fb_addr = AW'(addr);
    step();
    i_fb_req  = 1'b0;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    repeat (3) step();
    total++; if (o_wr_rdy !== 1'b0) $display("FAIL reset_wr_rdy got=%b exp=0", o_wr_rdy); else passed++;
    total++; if (o_loaded !== 1'b0) $display("FAIL reset_loaded got=%b exp=0", o_loaded); else passed++;
    total++; if (o_load_done !== 1'b0) $display("FAIL reset_load_done got=%b exp=0", o_load_done); else passed++;
    total++; if (o_rd_err !== 1'b0) $display("FAIL reset_rd_err got=%b exp=0", o_rd_err); else passed++;
    for (int b = 0; b < 4; b++) begin
      total++; if (fbd[b] !== 8'h00) $display("FAIL reset_fb_data%0d got=%h exp=00", b, fbd[b]); else passed++;
    end
    rstn = 1'b1;
    step();
  endtask

  task automatic test_load_w3();
    int done_cnt = 0;
    int done_at  = -1;
    load_start(3);
    total++; if (o_wr_rdy !== 1'b1) $display("FAIL w3_wr_rdy_in_load got=%b exp=1", o_wr_rdy); else passed++;
    total++; if (o_loaded !== 1'b0) $display("FAIL w3_loaded_in_load got=%b exp=0", o_loaded); else passed++;
    for (int k = 0; k < 12; k++) begin
      i_wr_vld  = 1'b1;
      i_wr_data = DW'(k + 1);
      step();
      if (o_load_done === 1'b1) begin done_cnt++; done_at = k; end
    end
    i_wr_vld = 1'b0;
    step();
    if (o_load_done === 1'b1) done_cnt++;
    total++; if (done_cnt != 1) $display("FAIL w3_done_count got=%0d exp=1", done_cnt); else passed++;
    total++; if (done_at != 11) $display("FAIL w3_done_timing got=%0d exp=11", done_at); else passed++;
    total++; if (o_loaded !== 1'b1) $display("FAIL w3_loaded got=%b exp=1", o_loaded); else passed++;
    total++; if (o_wr_rdy !== 1'b0) $display("FAIL w3_wr_rdy_ready got=%b exp=0", o_wr_rdy); else passed++;
  endtask

  task automatic test_read_w3();
    logic [DW-1:0] held;
    for (int a = 0; a < 3; a++) begin
      read_req(a);
      for (int b = 0; b < 4; b++) begin
        total++;
        if (fbd[b] !== DW'(4*a + b + 1)) $display("FAIL rd_w3_a%0d_b%0d got=%h exp=%h", a, b, fbd[b], DW'(4*a + b + 1));
        else passed++;
      end
      total++; if (o_rd_err !== 1'b0) $display("FAIL rd_w3_err_a%0d got=%b exp=0", a, o_rd_err); else passed++;
    end
    held = fbd[3];
    step();
    total++; if (fbd[3] !== held) $display("FAIL rd_hold got=%h exp=%h", fbd[3], held); else passed++;
    total++; if (o_rd_err !== 1'b0) $display("FAIL rd_err_no_req got=%b exp=0", o_rd_err); else passed++;
    read_req(3);
    total++; if (o_rd_err !== 1'b1) $display("FAIL rd_w3_err_a3 got=%b exp=1", o_rd_err); else passed++;
    step();
    total++; if (o_rd_err !== 1'b0) $display("FAIL rd_err_pulse_width got=%b exp=0", o_rd_err); else passed++;
  endtask

  task automatic test_gaps_restart();
    logic [7:0] gap = 8'b1011_0110;
    int k = 0;
    int c = 0;
    bit acc;
    bit done_ok = 0;
    bit done_early = 0;
    load_start(3);
    while (k < 12 && c < 100) begin
      i_wr_vld     = gap[c % 8];
      i_wr_data    = DW'(8'h11 + k);
      i_load_start = (c == 5);
      i_load_words = (AW+1)'(1);
      acc = i_wr_vld && o_wr_rdy;
      step();
      if (acc) k++;
      if (o_load_done === 1'b1) begin
        if (k == 12 && acc) done_ok = 1;
        else done_early = 1;
      end
      c++;
    end
    i_wr_vld = 1'b0;
    i_load_start = 1'b0;
    total++; if (k != 12) $display("FAIL gaps_beats_accepted got=%0d exp=12", k); else passed++;
    total++; if (done_ok != 1'b1) $display("FAIL gaps_done_on_last got=%b exp=1", done_ok); else passed++;
    total++; if (done_early != 1'b0) $display("FAIL gaps_done_early got=%b exp=0", done_early); else passed++;
    step();
    total++; if (o_load_done !== 1'b0) $display("FAIL gaps_done_single got=%b exp=0", o_load_done); else passed++;
    total++; if (o_loaded !== 1'b1) $display("FAIL gaps_loaded got=%b exp=1", o_loaded); else passed++;
    for (int a = 0; a < 3; a++) begin
      read_req(a);
      for (int b = 0; b < 4; b++) begin
        total++;
        if (fbd[b] !== DW'(8'h11 + 4*a + b)) $display("FAIL gaps_a%0d_b%0d got=%h exp=%h", a, b, fbd[b], DW'(8'h11 + 4*a + b));
        else passed++;
      end
    end
  endtask

  task automatic test_collision();
    int done_at = -1;
    load_start(3);
    total++; if (o_loaded !== 1'b0) $display("FAIL coll_loaded_drop got=%b exp=0", o_loaded); else passed++;
    i_wr_vld  = 1'b1;
    i_wr_data = 8'hAA;
    i_fb_req  = 1'b1;
    i_fb_addr = '0;
    step();
    i_wr_vld = 1'b0;
    i_fb_req = 1'b0;
    total++; if (fbd[0] !== 8'h11) $display("FAIL coll_old_data got=%h exp=11", fbd[0]); else passed++;
    total++; if (o_rd_err !== 1'b1) $display("FAIL coll_rd_err got=%b exp=1", o_rd_err); else passed++;
    read_req(0);
    total++; if (fbd[0] !== 8'hAA) $display("FAIL coll_new_data got=%h exp=aa", fbd[0]); else passed++;
    total++; if (o_rd_err !== 1'b1) $display("FAIL coll_rd_err_load got=%b exp=1", o_rd_err); else passed++;
    for (int k = 1; k < 12; k++) begin
      i_wr_vld  = 1'b1;
      i_wr_data = DW'(8'hA0 + k);
      step();
      if (o_load_done === 1'b1) done_at = k;
    end
    i_wr_vld = 1'b0;
    total++; if (done_at != 11) $display("FAIL coll_reload_done got=%0d exp=11", done_at); else passed++;
  endtask

  task automatic test_w0();
    i_wr_vld = 1'b1;
    load_start(0);
    total++; if (o_load_done !== 1'b1) $display("FAIL w0_done got=%b exp=1", o_load_done); else passed++;
    total++; if (o_loaded !== 1'b1) $display("FAIL w0_loaded got=%b exp=1", o_loaded); else passed++;
    total++; if (o_wr_rdy !== 1'b0) $display("FAIL w0_wr_rdy got=%b exp=0", o_wr_rdy); else passed++;
    step();
    i_wr_vld = 1'b0;
    total++; if (o_load_done !== 1'b0) $display("FAIL w0_done_pulse got=%b exp=0", o_load_done); else passed++;
    total++; if (o_wr_rdy !== 1'b0) $display("FAIL w0_wr_rdy_after got=%b exp=0", o_wr_rdy); else passed++;
    read_req(0);
    total++; if (o_rd_err !== 1'b1) $display("FAIL w0_rd_err got=%b exp=1", o_rd_err); else passed++;
    total++; if (fbd[0] !== 8'hAA) $display("FAIL w0_raw_data got=%h exp=aa", fbd[0]); else passed++;
  endtask

  task automatic test_reset_mid_load();
    int done_seen = 0;
    int done_at = -1;
    load_start(3);
    for (int k = 0; k < 5; k++) begin
      i_wr_vld  = 1'b1;
      i_wr_data = DW'(8'h21 + k);
      i_fb_req  = (k == 4);
      i_fb_addr = '0;
      step();
    end
    i_wr_vld = 1'b0;
    i_fb_req = 1'b0;
    total++; if (o_rd_err !== 1'b1) $display("FAIL rst_pre_rd_err got=%b exp=1", o_rd_err); else passed++;
    rstn = 1'b0;
    #2;
    total++; if (o_wr_rdy !== 1'b0) $display("FAIL rst_wr_rdy got=%b exp=0", o_wr_rdy); else passed++;
    total++; if (o_rd_err !== 1'b0) $display("FAIL rst_rd_err got=%b exp=0", o_rd_err); else passed++;
    total++; if (o_loaded !== 1'b0) $display("FAIL rst_loaded got=%b exp=0", o_loaded); else passed++;
    for (int b = 0; b < 4; b++) begin
      total++; if (fbd[b] !== 8'h00) $display("FAIL rst_fb_data%0d got=%h exp=00", b, fbd[b]); else passed++;
    end
    repeat (2) begin
      step();
      if (o_load_done === 1'b1) done_seen++;
    end
    rstn = 1'b1;
    step();
    if (o_load_done === 1'b1) done_seen++;
    total++; if (done_seen != 0) $display("FAIL rst_no_done got=%0d exp=0", done_seen); else passed++;
    total++; if (o_wr_rdy !== 1'b0) $display("FAIL rst_idle_wr_rdy got=%b exp=0", o_wr_rdy); else passed++;
    load_start(1);
    for (int k = 0; k < 4; k++) begin
      i_wr_vld  = 1'b1;
      i_wr_data = DW'(8'h31 + k);
      step();
      if (o_load_done === 1'b1) done_at = k;
    end
    i_wr_vld = 1'b0;
    total++; if (done_at != 3) $display("FAIL rst_w1_done got=%0d exp=3", done_at); else passed++;
    read_req(0);
    for (int b = 0; b < 4; b++) begin
      total++; if (fbd[b] !== DW'(8'h31 + b)) $display("FAIL rst_w1_b%0d got=%h exp=%h", b, fbd[b], DW'(8'h31 + b)); else passed++;
    end
    total++; if (o_rd_err !== 1'b0) $display("FAIL rst_w1_rd_err got=%b exp=0", o_rd_err); else passed++;
    read_req(1);
    total++; if (o_rd_err !== 1'b1) $display("FAIL rst_w1_rd_err_a1 got=%b exp=1", o_rd_err); else passed++;
  endtask

  task automatic test_back_to_back();
    i_fb_req  = 1'b1;
    i_fb_addr = 4'd0;
    step();
    total++; if (fbd[2] !== 8'h33) $display("FAIL b2b_a0 got=%h exp=33", fbd[2]); else passed++;
    total++; if (o_rd_err !== 1'b0) $display("FAIL b2b_a0_err got=%b exp=0", o_rd_err); else passed++;
    i_fb_addr = 4'd1;
    step();
    total++; if (o_rd_err !== 1'b1) $display("FAIL b2b_a1_err got=%b exp=1", o_rd_err); else passed++;
    total++; if (fbd[0] !== 8'h25) $display("FAIL b2b_a1_b0 got=%h exp=25", fbd[0]); else passed++;
    total++; if (fbd[1] !== 8'hA5) $display("FAIL b2b_a1_b1 got=%h exp=a5", fbd[1]); else passed++;
    i_fb_addr = 4'd0;
    step();
    i_fb_req = 1'b0;
    total++; if (fbd[0] !== 8'h31) $display("FAIL b2b_a0_again got=%h exp=31", fbd[0]); else passed++;
    total++; if (o_rd_err !== 1'b0) $display("FAIL b2b_a0_again_err got=%b exp=0", o_rd_err); else passed++;
  endtask

  task automatic test_saturate();
    int done_cnt = 0;
    int done_at = -1;
    load_start(20);
    for (int k = 0; k < 64; k++) begin
      i_wr_vld  = 1'b1;
      i_wr_data = DW'(k);
      step();
      if (o_load_done === 1'b1) begin done_cnt++; done_at = k; end
    end
    i_wr_vld = 1'b0;
    total++; if (done_cnt != 1) $display("FAIL sat_done_count got=%0d exp=1", done_cnt); else passed++;
    total++; if (done_at != 63) $display("FAIL sat_done_timing got=%0d exp=63", done_at); else passed++;
    read_req(15);
    for (int b = 0; b < 4; b++) begin
      total++; if (fbd[b] !== DW'(60 + b)) $display("FAIL sat_a15_b%0d got=%h exp=%h", b, fbd[b], DW'(60 + b)); else passed++;
    end
    total++; if (o_rd_err !== 1'b0) $display("FAIL sat_a15_err got=%b exp=0", o_rd_err); else passed++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog_timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

  initial begin
    rstn         = 1'b0;
    i_load_start = 1'b0;
    i_load_words = '0;
    i_wr_vld     = 1'b0;
    i_wr_data    = '0;
    i_fb_req     = 1'b0;
    i_fb_addr    = '0;
    test_reset();
    test_load_w3();
    test_read_w3();
    test_gaps_restart();
    test_collision();
    test_w0();
    test_reset_mid_load();
    test_back_to_back();
    test_saturate();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/filter_buffer.md
FILTER_BUFFER -- requirements
Module: filter_buffer

Interface
REQ-001 SHALL have parameter FILTER_DW, default `FILTER_DW, width of one filter word.
REQ-002 SHALL have parameter BUF_AW, default `BUFFER_ADDRESS_BW, read/write address width.
REQ-003 SHALL have parameter NB_FILTER, default `FILTER_BUFFER_CNT (4), number of banks; one bank per output lane.
REQ-004 SHALL use one clock and an asynchronous, active-low reset: clk  input  1  rising-edge clock; rstn  input  1  asynchronous active-low reset.
REQ-005 SHALL have port i_load_start  input  1  single-cycle pulse that starts a filter load.
REQ-006 SHALL have port i_load_words  input  BUF_AW+1  entries per bank for this load; sampled on i_load_start.
REQ-007 SHALL have port i_wr_vld  input  1  write-stream beat valid.
REQ-008 SHALL have port i_wr_data  input  FILTER_DW  write-stream beat data.
REQ-009 SHALL have port o_wr_rdy  output  1  write-stream ready.
REQ-010 SHALL have port o_loaded  output  1  level; buffer holds a complete load.
REQ-011 SHALL have port o_load_done  output  1  single-cycle pulse on completion of a load.
REQ-012 SHALL have port i_fb_req  input  1  read request from the PE engine.
REQ-013 SHALL have port i_fb_addr  input  BUF_AW  read address, common to all banks.
REQ-014 SHALL have ports fb_data0_out..fb_data3_out  output  FILTER_DW each  bank 0..3 read data.
REQ-015 SHALL have port o_rd_err  output  1  pulse, aligned with the read data, flagging an invalid read.

Function
REQ-016 SHALL implement a three-state FSM: IDLE, LOAD, READY.
REQ-017 In IDLE or READY, i_load_start SHALL latch i_load_words as W, clear the beat counter, drop o_loaded, and enter LOAD on the next cycle.
REQ-018 If latched W exceeds 2^BUF_AW, W SHALL saturate to 2^BUF_AW.
REQ-019 If W == 0, the block SHALL pulse o_load_done the next cycle, set o_loaded, enter READY, and accept no beats.
REQ-020 o_wr_rdy SHALL be 1 only in LOAD; a beat is accepted when i_wr_vld && o_wr_rdy.
REQ-021 Accepted beat k (0-based) SHALL be written to bank k mod NB_FILTER at address k / NB_FILTER.
REQ-022 When beat W*NB_FILTER-1 is accepted, the FSM SHALL enter READY, with o_load_done pulsing and o_loaded rising in the next cycle.
REQ-023 i_load_start during LOAD SHALL be ignored.
REQ-024 Read latency SHALL be exactly 1 cycle: i_fb_req at cycle t with address A drives all four banks' word A on fb_data*_out at t+1.
REQ-025 Without i_fb_req, fb_data*_out SHALL hold their last value.
REQ-026 o_rd_err SHALL pulse at t+1 if, at cycle t, the state was not READY or A >= W; data is still the raw memory content.
REQ-027 A read and a write to the same bank and address in the same cycle SHALL return the old data.
REQ-028 Reads SHALL never stall and SHALL be accepted every cycle, including back-to-back.
REQ-029 Arithmetic is unsigned; the beat counter SHALL be wide enough for 2^BUF_AW*NB_FILTER beats without wrap.

Reset
REQ-030 On rstn low, the block SHALL enter IDLE, and o_wr_rdy, o_loaded, o_load_done, o_rd_err, fb_data*_out, the beat counter and W SHALL be 0.
REQ-031 Memory contents SHALL NOT be reset; a reset during LOAD abandons the load, and o_load_done SHALL NOT pulse.

Verification
REQ-032 Load with W=3, 12 beats 0x01..0x0C, continuous vld -> bank0 addr0..2 = 01,05,09; bank3 addr2 = 0C; o_load_done pulses once, the cycle after the 12th beat.
REQ-033 After the REQ-032 load, req addr 1 -> next cycle data0..3 = 05,06,07,08 with o_rd_err=0; req addr 3 -> o_rd_err=1.
REQ-034 Random i_wr_vld gaps plus an i_load_start pulse mid-LOAD -> beat placement identical to REQ-032, and the second start is ignored.
REQ-035 i_load_start with W=0 -> o_load_done and o_loaded the next cycle; o_wr_rdy stays 0.
REQ-036 Assert rstn low after 5 beats -> all outputs 0 and IDLE; a new load with W=1 then completes normally after 4 beats.
REQ-037 Reading addr 0 in the same cycle that a reload writes bank0 addr0 -> old value returned, and o_rd_err=1 (state LOAD).
